busca_instrucao: RTL and testbench

Instruction fetch unit: the read-side master of `memoria_instrucao`. It holds the program counter and drives the 10-bit word address. It samples the memory's combinational read data and queues fetched words with their PC in a 2-entry prefetch buffer. It presents them to decode through a valid/ready handshake, and handles branch redirects, a start gate (so the memory can be loaded first) and halt detection.

---
 rtl/busca_instrucao_if.sv | 34 +++
 rtl/busca_instrucao.sv | 108 ++++++++++
 tb/tb_busca_instrucao.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/busca_instrucao_if.sv
// Fetch-side bus: instruction memory read port plus the decode handshake and redirect inputs.
// The fetch unit is the master; memory and decode together form the slave side.
interface busca_instrucao_if;
  logic [9:0]  ADDRESS;
  logic [31:0] Q;
  logic [31:0] INSTR;
  logic [31:0] PC_OUT;
  logic        IF_VALID;
  logic        ID_READY;
  logic        BR_TAKEN;
  logic [31:0] BR_TARGET;

  modport master (
    output ADDRESS,
    output INSTR,
    output PC_OUT,
    output IF_VALID,
    input  Q,
    input  ID_READY,
    input  BR_TAKEN,
    input  BR_TARGET
  );

  modport slave (
    input  ADDRESS,
    input  INSTR,
    input  PC_OUT,
    input  IF_VALID,
    output Q,
    output ID_READY,
    output BR_TAKEN,
    output BR_TARGET
  );
endinterface

// File: rtl/busca_instrucao.sv
// Instruction fetch unit: PC register, 2-entry prefetch buffer toward decode,
// branch redirect, start gate and halt detection.
module busca_instrucao #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int          DEPTH     = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  busca_instrucao_if.master bus,
  output logic              HALTED,
  output logic [31:0]       FETCH_COUNT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [1:0]  FULL     = 2'(DEPTH);
  localparam logic [31:0] WORD_MSK = 32'hFFFF_FFFC;

  state_t      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] ent_pc  [2];
  logic [31:0] ent_ins [2];

  logic        not_empty;
  logic        pop;
  logic        push;
  logic        redirect;
  logic        is_halt;
  logic [1:0]  tail;

  assign not_empty = (count_q != 2'd0);
  assign pop       = not_empty && bus.ID_READY;
  assign redirect  = bus.BR_TAKEN && (state_q != IDLE);
  assign push      = (state_q == RUN) && !bus.BR_TAKEN && ((count_q < FULL) || pop);
  assign is_halt   = (bus.Q == HALT_WORD);
  // Slot the incoming word lands in, after any head shift caused by a pop
  assign tail      = count_q - {1'b0, pop};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = RUN;
      RUN:     if (push && is_halt) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (redirect) state_d = RUN;
  end

  always_comb begin
    count_d       = count_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    if (redirect) begin
      count_d = 2'd0;
      pc_d    = bus.BR_TARGET & WORD_MSK;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (push) begin
        pc_d          = pc_q + 32'd4;
        fetch_count_d = fetch_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      count_q       <= 2'd0;
      pc_q          <= RESET_PC & WORD_MSK;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Buffer storage is unreset; entries beyond count are masked at the outputs
  always_ff @(posedge CLK) begin
    if (pop) begin
      ent_pc[0]  <= ent_pc[1];
      ent_ins[0] <= ent_ins[1];
    end
    if (push) begin
      ent_pc[tail[0]]  <= pc_q;
      ent_ins[tail[0]] <= bus.Q;
    end
  end

  assign bus.ADDRESS  = pc_q[11:2];
  assign bus.IF_VALID = not_empty;
  assign bus.INSTR    = not_empty ? ent_ins[0] : 32'd0;
  assign bus.PC_OUT   = not_empty ? ent_pc[0]  : 32'd0;
  assign HALTED       = (state_q == HALT);
  assign FETCH_COUNT  = fetch_count_q;

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: start-gate vector table, hand-written corner sequences,
// then randomized traffic checked against a queue-based reference model.
module tb_busca_instrucao;

  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_HALT = 2;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST, START, HALTED;
  logic [31:0] FETCH_COUNT;
  logic        W_START, W_HALTED;
  logic [31:0] W_FC;

  logic [31:0] mem [0:1023];

  busca_instrucao_if bif ();
  busca_instrucao_if wif ();

  assign bif.Q = mem[bif.ADDRESS];
  assign wif.Q = mem[wif.ADDRESS];

  busca_instrucao #(.RESET_PC(32'h0000_0000), .HALT_WORD(HALTW), .DEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .START(START), .bus(bif),
    .HALTED(HALTED), .FETCH_COUNT(FETCH_COUNT)
  );

  busca_instrucao #(.RESET_PC(32'h0000_0FF8), .HALT_WORD(HALTW), .DEPTH(2)) u_wrap (
    .CLK(CLK), .RST(RST), .START(W_START), .bus(wif),
    .HALTED(W_HALTED), .FETCH_COUNT(W_FC)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_fc;
  int          m_st;

  typedef struct {
    logic        start;
    logic        rdy;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    logic [31:0] efc;
    logic [9:0]  ea;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic rdy,
                            input logic br, input logic [31:0] tgt);
    logic do_pop, do_push;
    ent_t e;
    if (r) begin
      mq.delete();
      m_pc = 32'h0;
      m_fc = 32'h0;
      m_st = S_IDLE;
    end else begin
      do_pop = (mq.size() > 0) && rdy;
      if (m_st != S_IDLE && br) begin
        mq.delete();
        m_pc = tgt & 32'hFFFF_FFFC;
        m_st = S_RUN;
      end else begin
        do_push = (m_st == S_RUN) && ((mq.size() < 2) || do_pop);
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          e.pc  = m_pc;
          e.ins = mem[m_pc[11:2]];
          mq.push_back(e);
          m_pc = m_pc + 32'd4;
          m_fc = m_fc + 32'd1;
          if (e.ins == HALTW) m_st = S_HALT;
        end
        if (m_st == S_IDLE && s) m_st = S_RUN;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic rdy,
                     input logic br, input logic [31:0] tgt);
    logic        ev;
    logic [31:0] ei, ep;
    RST           = r;
    START         = s;
    bif.ID_READY  = rdy;
    bif.BR_TAKEN  = br;
    bif.BR_TARGET = tgt;
    model_step(r, s, rdy, br, tgt);
    @(posedge CLK);
    #1;
    ev = (mq.size() > 0);
    ei = ev ? mq[0].ins : 32'd0;
    ep = ev ? mq[0].pc  : 32'd0;
    chk("m_valid",  32'(bif.IF_VALID), 32'(ev));
    chk("m_instr",  bif.INSTR, ei);
    chk("m_pc_out", bif.PC_OUT, ep);
    chk("m_addr",   {22'd0, bif.ADDRESS}, {22'd0, m_pc[11:2]});
    chk("m_halted", 32'(HALTED), 32'(m_st == S_HALT));
    chk("m_fcount", FETCH_COUNT, m_fc);
  endtask

  initial begin
    logic [31:0] got[$];
    logic [31:0] exp_seq [4];

    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 | i;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    mem[64] = 32'h6400_0040;

    W_START       = 1'b0;
    wif.ID_READY  = 1'b1;
    wif.BR_TAKEN  = 1'b0;
    wif.BR_TARGET = 32'h0;

    for (int i = 0; i < 5; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'd0, 10'd0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h00, 32'h0, 32'd0, 10'd0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h11, 32'h0, 32'd1, 10'd1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h22, 32'h4, 32'd2, 10'd2};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 32'h33, 32'h8, 32'd3, 10'd3};
    tbl[9] = '{1'b1, 1'b1, 1'b1, 32'h44, 32'hC, 32'd4, 10'd4};

    // Reset state
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("rst_valid",  32'(bif.IF_VALID), 32'd0);
    chk("rst_instr",  bif.INSTR, 32'd0);
    chk("rst_pc_out", bif.PC_OUT, 32'd0);
    chk("rst_halted", 32'(HALTED), 32'd0);
    chk("rst_fcount", FETCH_COUNT, 32'd0);

    // Start gate and throughput
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, tbl[i].start, tbl[i].rdy, 1'b0, 32'h0);
      chk("tbl_valid",  32'(bif.IF_VALID), 32'(tbl[i].ev));
      chk("tbl_instr",  bif.INSTR, tbl[i].ei);
      chk("tbl_pc_out", bif.PC_OUT, tbl[i].ep);
      chk("tbl_fcount", FETCH_COUNT, tbl[i].efc);
      chk("tbl_addr",   {22'd0, bif.ADDRESS}, {22'd0, tbl[i].ea});
    end

    // Backpressure: only two pushes, then release delivers in order
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("bp_fcount", FETCH_COUNT, 32'd2);
    chk("bp_addr",   {22'd0, bif.ADDRESS}, 32'd2);
    chk("bp_head",   bif.INSTR, 32'h11);
    exp_seq[0] = 32'h11; exp_seq[1] = 32'h22; exp_seq[2] = 32'h33; exp_seq[3] = 32'h44;
    for (int i = 0; i < 3; i++) begin
      chk("bp_deliver", bif.INSTR, exp_seq[i]);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    end

    // Redirect while full
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0103);
    chk("br_empty", 32'(bif.IF_VALID), 32'd0);
    chk("br_addr",  {22'd0, bif.ADDRESS}, 32'd64);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("br_valid",  32'(bif.IF_VALID), 32'd1);
    chk("br_pc_out", bif.PC_OUT, 32'h100);
    chk("br_instr",  bif.INSTR, 32'h6400_0040);

    // Halt detection, drain, and resume by redirect
    mem[3] = HALTW;
    exp_seq[3] = HALTW;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      if (bif.IF_VALID) got.push_back(bif.INSTR);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    end
    chk("halt_ndeliv", got.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk("halt_deliver", (i < got.size()) ? got[i] : 32'hDEAD_BEEF, exp_seq[i]);
    chk("halt_flag",   32'(HALTED), 32'd1);
    chk("halt_fcount", FETCH_COUNT, 32'd4);
    chk("halt_valid",  32'(bif.IF_VALID), 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
    chk("resume_halted", 32'(HALTED), 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("resume_valid", 32'(bif.IF_VALID), 32'd1);
    chk("resume_instr", bif.INSTR, 32'h11);
    mem[3] = 32'h44;

    // Reset while full, with a redirect in flight
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
    chk("mrst_valid",  32'(bif.IF_VALID), 32'd0);
    chk("mrst_instr",  bif.INSTR, 32'd0);
    chk("mrst_pc_out", bif.PC_OUT, 32'd0);
    chk("mrst_fcount", FETCH_COUNT, 32'd0);
    chk("mrst_addr",   {22'd0, bif.ADDRESS}, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("mrst_idle_fc",    FETCH_COUNT, 32'd0);
    chk("mrst_idle_valid", 32'(bif.IF_VALID), 32'd0);

    // Address wrap on the second instance
    chk("wrap_addr0", {22'd0, wif.ADDRESS}, 32'd1022);
    W_START = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr1", {22'd0, wif.ADDRESS}, 32'd1022);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr2", {22'd0, wif.ADDRESS}, 32'd1023);
    chk("wrap_pc0",   wif.PC_OUT, 32'hFF8);
    chk("wrap_ins0",  wif.INSTR, 32'h1000_03FE);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr3", {22'd0, wif.ADDRESS}, 32'd0);
    chk("wrap_pc1",   wif.PC_OUT, 32'hFFC);
    chk("wrap_ins1",  wif.INSTR, 32'h1000_03FF);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr4", {22'd0, wif.ADDRESS}, 32'd1);
    chk("wrap_pc2",   wif.PC_OUT, 32'h1000);
    chk("wrap_ins2",  wif.INSTR, 32'h11);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap_pc3",   wif.PC_OUT, 32'h1004);
    chk("wrap_ins3",  wif.INSTR, 32'h22);
    W_START = 1'b0;

    // Randomized traffic against the reference model
    for (int i = 0; i < 1024; i++) mem[i] = ($urandom_range(0, 31) == 0) ? HALTW : $urandom;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 11) == 0),
          $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
